// File: rtl/cpu_program_sequencer.sv
// cpu_program_sequencer
// Owns the program counter, fetches instruction/data words from the ROM and
// hands them to the cpu core with a start/done handshake. Supports free-run
// (run=1) and single-step (run=0, step pulse) execution, halts after the last
// program word, and can be restarted from address 0 at any time.
//
// Optional feature: define SEQ_WATCHDOG_EN to build a WAIT-state watchdog that
// moves to FAULT when the cpu gives no done edge within WDOG_CYCLES cycles.
// Without the macro no counter is built and fault is tied low.
module cpu_program_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int PROG_LEN    = 16,
    parameter int WDOG_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              restart,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [8:0]        rom_instr,
    input  logic [15:0]       rom_data,
    output logic              cpu_start,
    output logic [8:0]        cpu_instruction,
    output logic [15:0]       cpu_data_var,
    input  logic              cpu_done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [2:0]        state
);

    // Encodings are visible on the LEDs, so they are fixed explicitly.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_ADVANCE = 3'd4,
        S_HALT    = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    // Reject impossible configurations at elaboration time.
    if (PROG_LEN < 1 || PROG_LEN > (1 << ADDR_W) || WDOG_CYCLES < 1) begin : g_param_check
        $error("cpu_program_sequencer: PROG_LEN must be 1..2**ADDR_W and WDOG_CYCLES >= 1");
    end

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              done_q;
    logic              done_rise;
    logic              wdog_expired;
    logic              cpu_start_q;
    logic              busy_q;
    logic              halted_q;
    logic [8:0]        instr_q;
    logic [15:0]       data_q;

    // Only a fresh rising edge of done completes an instruction; a level held
    // over from the previous instruction is already reflected in done_q.
    assign done_rise = cpu_done & ~done_q;

`ifdef SEQ_WATCHDOG_EN
    localparam int               WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              fault_q;

    // Watchdog: zero outside WAIT, so it starts from 0 on every WAIT entry and
    // counts the WAIT cycles spent on the current instruction.
    always_ff @(posedge clk) begin
        if (rst || state_q != S_WAIT) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    // The WDOG_CYCLES-th WAIT cycle without a done edge is the last one.
    assign wdog_expired = (state_q == S_WAIT) && (wdog_cnt == WDOG_LAST);

    // Registered fault flag, high exactly while the FSM sits in FAULT.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_d == S_FAULT);
        end
    end

    assign fault = fault_q;
`else
    assign wdog_expired = 1'b0;
    assign fault        = 1'b0;
`endif

    // Next-state and next-pc logic; restart overrides everything below it.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned, which would infer a latch.
        state_d = state_q;
        pc_d    = pc_q;

        case (state_q)
            S_IDLE: begin
                // run alone starts free-run; step only matters when run is low,
                // and run||step covers both cases.
                if (run || step) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    state_d = S_ADVANCE;
                end else if (wdog_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_ADVANCE: begin
                if (pc_q == LAST_PC) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_HALT, S_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // restart abandons whatever is in flight; the cpu itself is not reset.
        if (restart) begin
            state_d = S_IDLE;
            pc_d    = '0;
        end
    end

    // State, pc and registered status outputs, all decoded from the next state
    // so they line up with the state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            done_q      <= 1'b0;
            cpu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            done_q      <= cpu_done;
            cpu_start_q <= (state_d == S_ISSUE);
            busy_q      <= (state_d == S_FETCH) || (state_d == S_ISSUE) ||
                           (state_d == S_WAIT)  || (state_d == S_ADVANCE);
            halted_q    <= (state_d == S_HALT);
        end
    end

    // Capture the ROM words at the end of FETCH and hold them for the cpu
    // until the next fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            data_q  <= '0;
        end else if (state_q == S_FETCH) begin
            instr_q <= rom_instr;
            data_q  <= rom_data;
        end
    end

    assign rom_addr        = pc_q;
    assign pc              = pc_q;
    assign state           = state_q;
    assign cpu_start       = cpu_start_q;
    assign cpu_instruction = instr_q;
    assign cpu_data_var    = data_q;
    assign busy            = busy_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Testbench for cpu_program_sequencer.
// A scoreboard queue holds the instructions the program should issue, in
// order; a monitor pops one entry per cpu_start pulse and compares the issued
// address and words. A small cpu model answers start with done (pulse or held
// level) after a random latency. ROM contents are random.
module tb_cpu_program_sequencer;

    localparam int ADDR_W      = 3;
    localparam int PROG_LEN    = 4;
    localparam int WDOG_CYCLES = 10;
    localparam int ROM_DEPTH   = 1 << ADDR_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd5;
    localparam logic [2:0] ST_FAULT = 3'd6;

    typedef enum int {CPU_PULSE, CPU_HOLD, CPU_NEVER} cpu_mode_t;

    typedef struct {
        int          pc;
        logic [8:0]  instr;
        logic [15:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              step;
    logic              restart;
    logic [ADDR_W-1:0] rom_addr;
    logic [8:0]        rom_instr;
    logic [15:0]       rom_data;
    logic              cpu_start;
    logic [8:0]        cpu_instruction;
    logic [15:0]       cpu_data_var;
    logic              cpu_done;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              fault;
    logic [2:0]        state;

    logic [8:0]  rom_i [ROM_DEPTH];
    logic [15:0] rom_d [ROM_DEPTH];

    int        tests_run    = 0;
    int        tests_failed = 0;
    int        model_pc;
    bit        model_halted;
    exp_t      exp_q[$];
    cpu_mode_t cpu_mode;
    int        abort_req;
    int        start_count;

    cpu_program_sequencer #(
        .ADDR_W      (ADDR_W),
        .PROG_LEN    (PROG_LEN),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .step            (step),
        .restart         (restart),
        .rom_addr        (rom_addr),
        .rom_instr       (rom_instr),
        .rom_data        (rom_data),
        .cpu_start       (cpu_start),
        .cpu_instruction (cpu_instruction),
        .cpu_data_var    (cpu_data_var),
        .cpu_done        (cpu_done),
        .pc              (pc),
        .busy            (busy),
        .halted          (halted),
        .fault           (fault),
        .state           (state)
    );

    always #5 clk = ~clk;

    // Combinational ROM (read latency 0).
    assign rom_instr = rom_i[rom_addr];
    assign rom_data  = rom_d[rom_addr];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: the program runs addresses 0..PROG_LEN-1 in order and
    // stops after the last one. Each accepted execution request queues the
    // instruction that must appear next on the cpu side.
    task automatic issue_expect();
        exp_t e;
        if (model_halted) return;
        e.pc    = model_pc;
        e.instr = rom_i[model_pc];
        e.data  = rom_d[model_pc];
        exp_q.push_back(e);
        if (model_pc == PROG_LEN - 1) model_halted = 1'b1;
        else model_pc++;
    endtask

    // cpu model: after start, done rises lat+1 negedges later (lat 1..3).
    // Pulse mode: done is high for one cycle. Hold mode: done keeps its old
    // level until one cycle before completion, drops, then rises and stays.
    task automatic cpu_loop();
        bit pend = 1'b0;
        int cnt  = 0;
        int seen = 0;
        cpu_done = 1'b0;
        forever begin
            @(negedge clk);
            if (abort_req != seen) begin
                seen     = abort_req;
                pend     = 1'b0;
                cpu_done = 1'b0;
            end
            if (cpu_mode == CPU_PULSE) cpu_done = 1'b0;
            if (cpu_start) begin
                pend = (cpu_mode != CPU_NEVER);
                cnt  = int'($urandom_range(3, 1)) + 1;
            end else if (pend) begin
                cnt--;
                if (cnt == 1 && cpu_mode == CPU_HOLD) cpu_done = 1'b0;
                if (cnt == 0) begin
                    cpu_done = 1'b1;
                    pend     = 1'b0;
                end
            end
        end
    endtask

    // Monitor: every start pulse must match the next queued instruction, be a
    // single cycle wide, and the issued words must stay stable through WAIT.
    task automatic monitor_loop();
        bit          prev_start = 1'b0;
        logic [8:0]  held_instr = '0;
        logic [15:0] held_data  = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (cpu_start) begin
                start_count++;
                check("start_one_cycle", 32'(prev_start), 32'd0);
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_start: pc=%0d, expected no instruction (t=%0t)", pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("start_pc", 32'(pc), e.pc);
                    check("start_rom_addr", 32'(rom_addr), e.pc);
                    check("start_instr", 32'(cpu_instruction), 32'(e.instr));
                    check("start_data", 32'(cpu_data_var), 32'(e.data));
                    held_instr = e.instr;
                    held_data  = e.data;
                end
            end
            if (state == ST_WAIT) begin
                check("wait_instr_stable", 32'(cpu_instruction), 32'(held_instr));
                check("wait_data_stable", 32'(cpu_data_var), 32'(held_data));
            end
            prev_start = cpu_start;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        abort_req++;
        model_pc     = 0;
        model_halted = 1'b0;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        int n = 0;
        while (state != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(state), 32'(target));
    endtask

    task automatic wait_settled(input int budget, input string name);
        int n = 0;
        while (!(state == ST_IDLE || state == ST_HALT) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(state == ST_IDLE || state == ST_HALT), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'(ST_IDLE));
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_cpu_start"}, 32'(cpu_start), 32'd0);
        check({tag, "_instr"}, 32'(cpu_instruction), 32'd0);
        check({tag, "_data"}, 32'(cpu_data_var), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    task automatic stimulus();
        int starts_before;
        int r;

        // Reset with run low.
        tick(3);
        check_reset_values("reset");
        rst = 1'b0;
        tick(4);
        check("idle_without_run", 32'(state), 32'(ST_IDLE));

        // Single step from IDLE: FETCH next cycle, start two cycles after step.
        cpu_mode = CPU_PULSE;
        issue_expect();
        pulse_step();
        check("step_fetch_state", 32'(state), 32'(ST_FETCH));
        check("step_rom_addr", 32'(rom_addr), 32'd0);
        check("step_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("step_start_latency", 32'(cpu_start), 32'd1);
        check("step_instr_rom0", 32'(cpu_instruction), 32'(rom_i[0]));
        check("step_data_rom0", 32'(cpu_data_var), 32'(rom_d[0]));
        wait_settled(30, "step0_settle");
        check("step0_pc", 32'(pc), model_pc);

        issue_expect();
        pulse_step();
        wait_settled(30, "step1_settle");
        check("step1_pc", 32'(pc), model_pc);

        // Instruction 2 never completes; step pulses while busy are ignored,
        // then restart in WAIT returns to IDLE at address 0.
        cpu_mode = CPU_NEVER;
        issue_expect();
        pulse_step();
        pulse_step();
        wait_state(ST_WAIT, 10, "pc2_reach_wait");
        check("pc2_wait_pc", 32'(pc), 32'd2);
        pulse_step();
        tick(3);
        check("pc2_still_wait", 32'(state), 32'(ST_WAIT));
        check("pc2_busy", 32'(busy), 32'd1);
        pulse_restart();
        check("restart_pc", 32'(pc), 32'd0);
        check("restart_state", 32'(state), 32'(ST_IDLE));
        check("restart_cpu_start", 32'(cpu_start), 32'd0);
        check("restart_busy", 32'(busy), 32'd0);
        tick(4);
        check("restart_stays_idle", 32'(state), 32'(ST_IDLE));

        // Free-run to the end of the program with a pulsed done.
        cpu_mode = CPU_PULSE;
        starts_before = start_count;
        while (!model_halted) issue_expect();
        run = 1'b1;
        wait_state(ST_HALT, 200, "freerun_halt");
        check("freerun_pc", 32'(pc), PROG_LEN - 1);
        check("freerun_halted", 32'(halted), 32'd1);
        check("freerun_busy", 32'(busy), 32'd0);
        check("freerun_starts", start_count - starts_before, PROG_LEN);
        run = 1'b0;
        pulse_step();
        tick(5);
        check("halt_ignores_step", 32'(state), 32'(ST_HALT));
        check("halt_pc_kept", 32'(pc), PROG_LEN - 1);

        // Free-run with done held high across instructions.
        pulse_restart();
        cpu_mode = CPU_HOLD;
        starts_before = start_count;
        while (!model_halted) issue_expect();
        run = 1'b1;
        wait_state(ST_HALT, 300, "hold_halt");
        check("hold_pc", 32'(pc), PROG_LEN - 1);
        check("hold_starts", start_count - starts_before, PROG_LEN);
        run = 1'b0;

        // Drop run during WAIT at pc=1: finish that instruction, then IDLE.
        pulse_restart();
        cpu_mode = CPU_PULSE;
        issue_expect();
        pulse_step();
        wait_settled(30, "rundrop_step0");
        issue_expect();
        run = 1'b1;
        wait_state(ST_WAIT, 20, "rundrop_wait");
        check("rundrop_wait_pc", 32'(pc), 32'd1);
        run = 1'b0;
        wait_state(ST_IDLE, 30, "rundrop_idle");
        check("rundrop_pc", 32'(pc), 32'd2);
        tick(8);
        check("rundrop_no_more", 32'(state), 32'(ST_IDLE));
        check("rundrop_queue_empty", exp_q.size(), 32'd0);
        issue_expect();
        pulse_step();
        wait_settled(30, "rundrop_step2");
        check("rundrop_step2_pc", 32'(pc), model_pc);

        // rst in mid-operation wins over a simultaneous restart.
        pulse_restart();
        while (!model_halted) issue_expect();
        run = 1'b1;
        tick(6);
        rst     = 1'b1;
        restart = 1'b1;
        run     = 1'b0;
        abort_req++;
        @(negedge clk);
        exp_q.delete();
        model_pc     = 0;
        model_halted = 1'b0;
        check_reset_values("midrst");
        rst     = 1'b0;
        restart = 1'b0;
        tick(2);

        // Random mix of steps, free-runs and restarts.
        for (int it = 0; it < 30; it++) begin
            cpu_mode = ($urandom_range(1, 0) == 0) ? CPU_PULSE : CPU_HOLD;
            r = int'($urandom_range(9, 0));
            if (r < 2) begin
                pulse_restart();
            end else if (r < 4) begin
                while (!model_halted) issue_expect();
                run = 1'b1;
                wait_state(ST_HALT, 300, "rand_run_halt");
                run = 1'b0;
            end else begin
                issue_expect();
                pulse_step();
            end
            wait_settled(50, "rand_settle");
            check("rand_pc", 32'(pc), model_pc);
            check("rand_halted", 32'(halted), 32'(model_halted));
        end

`ifdef SEQ_WATCHDOG_EN
        // cpu never answers: FAULT after exactly WDOG_CYCLES WAIT cycles.
        begin
            int n = 0;
            pulse_restart();
            cpu_mode = CPU_NEVER;
            issue_expect();
            pulse_step();
            wait_state(ST_WAIT, 10, "wdog_reach_wait");
            while (state == ST_WAIT && n < 100) begin
                n++;
                @(negedge clk);
            end
            check("wdog_wait_cycles", n, WDOG_CYCLES);
            check("wdog_state", 32'(state), 32'(ST_FAULT));
            check("wdog_fault", 32'(fault), 32'd1);
            check("wdog_pc", 32'(pc), 32'd0);
            check("wdog_busy", 32'(busy), 32'd0);
            run = 1'b1;
            pulse_step();
            tick(3);
            check("wdog_sticky", 32'(state), 32'(ST_FAULT));
            run = 1'b0;
            pulse_restart();
            check("wdog_restart_fault", 32'(fault), 32'd0);
            check("wdog_restart_state", 32'(state), 32'(ST_IDLE));
        end
`else
        check("fault_tied_low", 32'(fault), 32'd0);
`endif
        tick(5);
    endtask

    initial begin
        rst          = 1'b1;
        run          = 1'b0;
        step         = 1'b0;
        restart      = 1'b0;
        cpu_mode     = CPU_PULSE;
        abort_req    = 0;
        start_count  = 0;
        model_pc     = 0;
        model_halted = 1'b0;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            rom_i[i] = 9'($urandom_range(511, 1));
            rom_d[i] = 16'($urandom_range(65535, 1));
        end

        fork
            cpu_loop();
            monitor_loop();
            stimulus();
            begin
                repeat (20000) @(negedge clk);
                tests_run++;
                tests_failed++;
                $display("FAIL global_timeout: stimulus did not complete within 20000 cycles");
            end
        join_any
        disable fork;

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
